// File: rtl/mult_wide_acc.sv
// Parametrised multi-lane multiply-add with optional accumulator: Z = base +/- A0*B0 +/- ...
// Input, product and output register stages are individually selectable; a valid bit rides along.
module mult_wide_acc #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned AW        = 9,
    parameter int unsigned BW        = 9,
    parameter int unsigned ZW        = 54,
    parameter int unsigned REG_IN    = 1,
    parameter int unsigned REG_PIPE  = 0,
    parameter int unsigned REG_OUT   = 1,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    input  logic [LANES*AW-1:0] A,
    input  logic [LANES*BW-1:0] B,
    input  logic [ZW-1:0]       C,
    input  logic [LANES-1:0]    ADDSUB,
    input  logic                SIGNED,
    input  logic                LOADC,
    input  logic                ACC_EN,
    output logic [ZW-1:0]       Z,
    output logic                OUT_VALID
);

    localparam int unsigned PW  = AW + BW;
    localparam int unsigned XW  = PW + 2;
    localparam int unsigned S1W = 1 + LANES*AW + LANES*BW + ZW + LANES + 3;
    localparam int unsigned S2W = 1 + LANES*ZW + ZW + LANES + 2;

    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("mult_wide_acc: LANES must be in 1..8");
    end
    if (ZW < AW + BW + $clog2(LANES) + 1) begin : g_bad_zw
        $error("mult_wide_acc: ZW too narrow for AW+BW+clog2(LANES)+1");
    end

    // ---------------- input stage ----------------
    logic [S1W-1:0] s1_d, s1;
    assign s1_d = {IN_VALID, A, B, C, ADDSUB, (SIGNED_EN != 0) && SIGNED, LOADC, ACC_EN};

    if (REG_IN != 0) begin : g_in_reg
        logic [S1W-1:0] s1_q;
        always_ff @(posedge CLK) begin
            if (RST) s1_q <= '0;
            else     s1_q <= s1_d;
        end
        assign s1 = s1_q;
    end else begin : g_in_byp
        assign s1 = s1_d;
    end

    logic                v1, sgn1, loadc1, accen1;
    logic [LANES*AW-1:0] a1;
    logic [LANES*BW-1:0] b1;
    logic [ZW-1:0]       c1;
    logic [LANES-1:0]    addsub1;
    assign {v1, a1, b1, c1, addsub1, sgn1, loadc1, accen1} = s1;

    // ---------------- lane products ----------------
    // Operands are extended to PW+2 bits so one unsigned multiply serves both signednesses;
    // the low PW bits then hold the exact product, extended to ZW by the operand mode.
    logic [LANES*ZW-1:0] p1;
    always_comb begin
        logic [XW-1:0] ea, eb, pr;
        p1 = '0;
        ea = '0;
        eb = '0;
        pr = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            ea = {{(XW-AW){sgn1 & a1[i*AW+AW-1]}}, a1[i*AW +: AW]};
            eb = {{(XW-BW){sgn1 & b1[i*BW+BW-1]}}, b1[i*BW +: BW]};
            pr = ea * eb;
            p1[i*ZW +: ZW] = {{(ZW-PW){sgn1 & pr[PW-1]}}, pr[PW-1:0]};
        end
    end

    // ---------------- product pipeline stage ----------------
    logic [S2W-1:0] s2_d, s2;
    assign s2_d = {v1, p1, c1, addsub1, loadc1, accen1};

    if (REG_PIPE != 0) begin : g_pipe_reg
        logic [S2W-1:0] s2_q;
        always_ff @(posedge CLK) begin
            if (RST) s2_q <= '0;
            else     s2_q <= s2_d;
        end
        assign s2 = s2_q;
    end else begin : g_pipe_byp
        assign s2 = s2_d;
    end

    logic                v2, loadc2, accen2;
    logic [LANES*ZW-1:0] p2;
    logic [ZW-1:0]       c2;
    logic [LANES-1:0]    addsub2;
    assign {v2, p2, c2, addsub2, loadc2, accen2} = s2;

    // ---------------- sum stage and accumulator ----------------
    logic [ZW-1:0] sum, base, result, acc_d, acc_q;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (addsub2[i]) sum = sum + p2[i*ZW +: ZW];
            else            sum = sum - p2[i*ZW +: ZW];
        end
        base   = (accen2 && !loadc2) ? acc_q : c2;
        result = base + sum;
        acc_d  = acc_q;
        if (v2 && accen2) acc_d = result;
    end

    always_ff @(posedge CLK) begin
        if (RST) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    // ---------------- output stage ----------------
    if (REG_OUT != 0) begin : g_out_reg
        logic [ZW-1:0] z_d, z_q;
        logic          ov_q;
        always_comb z_d = v2 ? result : z_q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                z_q  <= '0;
                ov_q <= 1'b0;
            end else begin
                z_q  <= z_d;
                ov_q <= v2;
            end
        end
        assign Z         = z_q;
        assign OUT_VALID = ov_q;
    end else begin : g_out_byp
        assign Z         = result;
        assign OUT_VALID = v2;
    end

endmodule

// File: tb/tb_mult_wide_acc.sv
// Bench for mult_wide_acc: directed vectors on default, unsigned-only and combinational builds,
// plus a randomized 2-lane 18x18 latency-3 build checked against a plain-arithmetic model.
module tb_mult_wide_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default-parameter stimulus (shared by u_dut, u_nosign, u_comb)
    logic        d_valid, d_signed, d_loadc, d_accen;
    logic [35:0] d_a, d_b;
    logic [53:0] d_c;
    logic [3:0]  d_addsub;
    logic [53:0] d_z, n_z, c_z;
    logic        d_ov, n_ov, c_ov;

    // wide build stimulus
    logic        w_valid, w_signed, w_loadc, w_accen;
    logic [35:0] w_a, w_b;
    logic [39:0] w_c;
    logic [1:0]  w_addsub;
    logic [39:0] w_z;
    logic        w_ov;

    int n_tests = 0;
    int n_fail  = 0;

    mult_wide_acc u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(d_valid), .A(d_a), .B(d_b), .C(d_c),
        .ADDSUB(d_addsub), .SIGNED(d_signed), .LOADC(d_loadc), .ACC_EN(d_accen),
        .Z(d_z), .OUT_VALID(d_ov)
    );

    mult_wide_acc #(.SIGNED_EN(0)) u_nosign (
        .CLK(clk), .RST(rst), .IN_VALID(d_valid), .A(d_a), .B(d_b), .C(d_c),
        .ADDSUB(d_addsub), .SIGNED(d_signed), .LOADC(d_loadc), .ACC_EN(d_accen),
        .Z(n_z), .OUT_VALID(n_ov)
    );

    mult_wide_acc #(.REG_IN(0), .REG_PIPE(0), .REG_OUT(0)) u_comb (
        .CLK(clk), .RST(rst), .IN_VALID(d_valid), .A(d_a), .B(d_b), .C(d_c),
        .ADDSUB(d_addsub), .SIGNED(d_signed), .LOADC(d_loadc), .ACC_EN(d_accen),
        .Z(c_z), .OUT_VALID(c_ov)
    );

    mult_wide_acc #(
        .LANES(2), .AW(18), .BW(18), .ZW(40), .REG_IN(1), .REG_PIPE(1), .REG_OUT(1)
    ) u_wide (
        .CLK(clk), .RST(rst), .IN_VALID(w_valid), .A(w_a), .B(w_b), .C(w_c),
        .ADDSUB(w_addsub), .SIGNED(w_signed), .LOADC(w_loadc), .ACC_EN(w_accen),
        .Z(w_z), .OUT_VALID(w_ov)
    );

    task automatic check(input string name, input logic got_ov, input logic [63:0] got_z,
                         input logic exp_ov, input logic [63:0] exp_z);
        n_tests++;
        if (got_ov !== exp_ov || got_z !== exp_z) begin
            n_fail++;
            $display("FAIL %s: got ov=%0b z=%0h, expected ov=%0b z=%0h",
                     name, got_ov, got_z, exp_ov, exp_z);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [35:0] a, b;
        logic [53:0] c;
        logic [3:0]  addsub;
        logic        sgn;
        logic [53:0] exp_z;   // SIGNED_EN=1 build
        logic [53:0] exp_nz;  // SIGNED_EN=0 build
    } vec_t;

    vec_t vt[5];

    task automatic idle_d();
        d_valid = 1'b0; d_a = '0; d_b = '0; d_c = '0; d_addsub = '0;
        d_signed = 1'b0; d_loadc = 1'b0; d_accen = 1'b0;
    endtask

    task automatic drive_vec(input int k);
        d_valid = 1'b1; d_a = vt[k].a; d_b = vt[k].b; d_c = vt[k].c;
        d_addsub = vt[k].addsub; d_signed = vt[k].sgn; d_loadc = 1'b0; d_accen = 1'b0;
    endtask

    task automatic run_table();
        vt[0] = '{"base", {9'd6, 9'd5, 9'd4, 9'd3}, {4{9'd2}}, 54'd100, 4'b1111, 1'b0,
                  54'd136, 54'd136};
        vt[1] = '{"signed", {27'd0, 9'h1FF}, {27'd0, 9'd2}, 54'd0, 4'b1111, 1'b1,
                  54'h3FFFFFFFFFFFFE, 54'd1022};
        vt[2] = '{"unsigned", {27'd0, 9'h1FF}, {27'd0, 9'd2}, 54'd0, 4'b1111, 1'b0,
                  54'd1022, 54'd1022};
        vt[3] = '{"subtract", {9'd6, 9'd5, 9'd4, 9'd3}, {4{9'd2}}, 54'd100, 4'b1110, 1'b0,
                  54'd124, 54'd124};
        vt[4] = '{"mixed", {9'h1FE, 9'd7, 9'h1FF, 9'd3}, {4{9'd5}}, 54'd50, 4'b0101, 1'b1,
                  54'd115, 54'h3FFFFFFFFFEC73};
        for (int k = 0; k < 5; k++) begin
            drive_vec(k);
            step();
            d_valid = 1'b0;
            step();
            check({vt[k].name, "_out"}, d_ov, 64'(d_z), 1'b1, 64'(vt[k].exp_z));
            check({vt[k].name, "_nosign"}, n_ov, 64'(n_z), 1'b1, 64'(vt[k].exp_nz));
            step();
            check({vt[k].name, "_hold"}, d_ov, 64'(d_z), 1'b0, 64'(vt[k].exp_z));
        end
        idle_d();
    endtask

    task automatic run_comb();
        drive_vec(0);
        #1;
        check("comb_same_cycle", c_ov, 64'(c_z), 1'b1, 64'd136);
        drive_vec(3);
        #1;
        check("comb_subtract", c_ov, 64'(c_z), 1'b1, 64'd124);
        d_valid = 1'b0;
        #1;
        check("comb_novalid", c_ov, 64'(c_z), 1'b0, 64'd124);
        idle_d();
        repeat (3) step();
    endtask

    typedef struct {
        logic        v, loadc, accen;
        logic [53:0] c;
        logic        exp_ov;
        logic [53:0] exp_z;
    } acc_t;

    task automatic run_acc();
        acc_t sq[6];
        sq[0] = '{1'b1, 1'b1, 1'b1, 54'd10,  1'b1, 54'd46};
        sq[1] = '{1'b1, 1'b0, 1'b1, 54'd999, 1'b1, 54'd82};
        sq[2] = '{1'b0, 1'b0, 1'b1, 54'd999, 1'b0, 54'd82};
        sq[3] = '{1'b1, 1'b0, 1'b1, 54'd999, 1'b1, 54'd118};
        sq[4] = '{1'b1, 1'b0, 1'b0, 54'd0,   1'b1, 54'd36};
        sq[5] = '{1'b1, 1'b0, 1'b1, 54'd999, 1'b1, 54'd154};
        drive_vec(0);
        for (int t = 0; t <= 6; t++) begin
            if (t < 6) begin
                d_valid = sq[t].v; d_loadc = sq[t].loadc; d_accen = sq[t].accen; d_c = sq[t].c;
            end else begin
                d_valid = 1'b0;
            end
            step();
            if (t >= 1)
                check($sformatf("acc_seq%0d", t - 1), d_ov, 64'(d_z),
                      sq[t-1].exp_ov, 64'(sq[t-1].exp_z));
        end
        idle_d();
    endtask

    task automatic run_reset();
        drive_vec(0);
        step();
        rst = 1'b1;      // valid held high too: reset must win
        step();
        check("rst_flush", d_ov, 64'(d_z), 1'b0, 64'd0);
        rst = 1'b0;
        d_valid = 1'b0;
        step();
        check("rst_no_ov1", d_ov, 64'(d_z), 1'b0, 64'd0);
        step();
        check("rst_no_ov2", d_ov, 64'(d_z), 1'b0, 64'd0);
        drive_vec(0);
        step();
        d_valid = 1'b0;
        check("post_rst_l1", d_ov, 64'(d_z), 1'b0, 64'd0);
        step();
        check("post_rst_l2", d_ov, 64'(d_z), 1'b1, 64'd136);
        // accumulator cleared by reset: acc 0 + 36
        drive_vec(0);
        d_accen = 1'b1;
        step();
        d_valid = 1'b0;
        step();
        check("post_rst_acc", d_ov, 64'(d_z), 1'b1, 64'd36);
        idle_d();
    endtask

    function automatic longint opv(input logic [17:0] v, input logic s);
        longint r;
        r = longint'({46'd0, v});
        if (s && v[17]) r = r - 64'sd262144;
        return r;
    endfunction

    task automatic run_random();
        localparam int N = 1000;
        logic        eov[N];
        logic [39:0] ez[N];
        logic [39:0] macc, mz, base;
        logic [63:0] r, tot;
        longint      s, p;
        macc = '0;
        mz   = '0;
        for (int t = 0; t < N + 2; t++) begin
            if (t < N) begin
                w_valid  = ($urandom_range(0, 9) != 0);
                r = {$urandom, $urandom}; w_a = r[35:0];
                r = {$urandom, $urandom}; w_b = r[35:0];
                if ($urandom_range(0, 7) == 0) w_a = {18'h20000, 18'h3FFFF};
                r = {$urandom, $urandom}; w_c = r[39:0];
                if ($urandom_range(0, 7) == 0) w_c = 40'hFF_FFFF_FF00 | 40'($urandom_range(0, 255));
                w_addsub = 2'($urandom_range(0, 3));
                w_signed = ($urandom_range(0, 3) != 0);
                w_loadc  = ($urandom_range(0, 3) == 0);
                w_accen  = ($urandom_range(0, 2) != 0);
                if (w_valid) begin
                    s = 0;
                    for (int i = 0; i < 2; i++) begin
                        p = opv(w_a[i*18 +: 18], w_signed) * opv(w_b[i*18 +: 18], w_signed);
                        s = w_addsub[i] ? s + p : s - p;
                    end
                    base = (w_accen && !w_loadc) ? macc : w_c;
                    tot  = {24'd0, base} + s;
                    mz   = tot[39:0];
                    if (w_accen) macc = mz;
                end
                eov[t] = w_valid;
                ez[t]  = mz;
            end else begin
                w_valid = 1'b0;
            end
            step();
            if (t >= 2) check($sformatf("rand%0d", t - 2), w_ov, 64'(w_z), eov[t-2], 64'(ez[t-2]));
        end
        w_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_d();
        w_valid = 1'b0; w_a = '0; w_b = '0; w_c = '0; w_addsub = '0;
        w_signed = 1'b0; w_loadc = 1'b0; w_accen = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_dut", d_ov, 64'(d_z), 1'b0, 64'd0);
        check("reset_wide", w_ov, 64'(w_z), 1'b0, 64'd0);
        run_random();
        run_table();
        run_comb();
        run_acc();
        run_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
